// File: rtl/f_stage.sv
// f_stage: MIPS fetch stage owning the PC, next-PC select, AdEL detection
// and the discard of the instruction fetched behind an eret.
module f_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
   parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        int_req,
   input  logic        stall,
   input  logic        eret_d,
   input  logic [31:0] epc,
   input  logic [1:0]  npc_sel,
   input  logic        is_jump_d,
   input  logic [31:0] pc_d,
   input  logic [15:0] imm16_d,
   input  logic [25:0] index_d,
   input  logic [31:0] rs_val_d,
   output logic [31:0] i_addr,
   input  logic [31:0] i_rdata,
   output logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic        bd_f,
   output logic [4:0]  exccode_f
);
   logic [31:0] fpc_q, fpc_d, br_tgt, j_tgt, redir;
   logic        adel, discard;
   always_comb begin
      br_tgt = pc_d + 32'd4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
      j_tgt  = {pc_d[31:28], index_d, 2'b00};
      redir  = npc_sel == 2'b01 ? br_tgt :
               npc_sel == 2'b10 ? j_tgt :
               npc_sel == 2'b11 ? rs_val_d : fpc_q + 32'd4;
      fpc_d  = reset ? RESET_PC : int_req ? HANDLER_PC : stall ? fpc_q : eret_d ? epc : redir;
   end
   always_ff @(posedge clk) fpc_q <= fpc_d;
   // eret has no delay slot, so whatever sits in F behind it is dropped
   assign discard   = eret_d & ~stall;
   assign adel      = (|fpc_q[1:0]) | (fpc_q < TEXT_LO) | (fpc_q > TEXT_HI);
   assign i_addr    = fpc_q;
   assign pc_f      = fpc_q;
   assign instr_f   = (discard | adel) ? 32'd0 : i_rdata;
   assign exccode_f = (!discard && adel) ? 5'd4 : 5'd0;
   assign bd_f      = is_jump_d & ~discard;
endmodule

// File: tb/tb_f_stage.sv
// tb_f_stage: randomized scoreboard bench for f_stage against an
// address-level reference model of the fetch rules.
module tb_f_stage;
   logic        clk = 1'b0;
   logic        reset, int_req, stall, eret_d, is_jump_d;
   logic [31:0] epc, pc_d, rs_val_d, i_addr, i_rdata, instr_f, pc_f;
   logic [1:0]  npc_sel;
   logic [15:0] imm16_d;
   logic [25:0] index_d;
   logic        bd_f;
   logic [4:0]  exccode_f;

   typedef struct {
      logic        chk;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        bd;
      logic [4:0]  exc;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] mpc;
   logic        mvalid = 1'b0;

   f_stage dut (
      .clk(clk), .reset(reset), .int_req(int_req), .stall(stall), .eret_d(eret_d),
      .epc(epc), .npc_sel(npc_sel), .is_jump_d(is_jump_d), .pc_d(pc_d),
      .imm16_d(imm16_d), .index_d(index_d), .rs_val_d(rs_val_d), .i_addr(i_addr),
      .i_rdata(i_rdata), .instr_f(instr_f), .pc_f(pc_f), .bd_f(bd_f), .exccode_f(exccode_f)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ ~a[15:0]};
   endfunction

   assign i_rdata = mem(i_addr);

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         if (e.chk) begin
            cmp("pc_f", pc_f, e.pc);
            cmp("i_addr", i_addr, e.pc);
            cmp("instr_f", instr_f, e.instr);
            cmp("bd_f", {31'd0, bd_f}, {31'd0, e.bd});
            cmp("exccode_f", {27'd0, exccode_f}, {27'd0, e.exc});
         end
      end
   end

   // One cycle: drive, predict this cycle's outputs, then advance the model PC.
   task automatic step(input logic rst, input logic ir, input logic st, input logic er,
                       input logic [31:0] ep, input logic [1:0] ns, input logic ij,
                       input logic [31:0] pd, input logic [15:0] im, input logic [25:0] ix,
                       input logic [31:0] rs);
      exp_t        e;
      logic        bad, disc;
      logic [31:0] nxt;
      int          off;
      reset = rst; int_req = ir; stall = st; eret_d = er; epc = ep; npc_sel = ns;
      is_jump_d = ij; pc_d = pd; imm16_d = im; index_d = ix; rs_val_d = rs;
      bad  = (mpc % 4 != 0) || (mpc < 32'h3000) || (mpc > 32'h6FFC);
      disc = er && !st;
      e.chk   = mvalid;
      e.pc    = mpc;
      e.instr = (disc || bad) ? 32'd0 : mem(mpc);
      e.exc   = (!disc && bad) ? 5'd4 : 5'd0;
      e.bd    = ij && !disc;
      sb.push_back(e);
      off = int'($signed(im));
      if (rst) nxt = 32'h3000;
      else if (ir) nxt = 32'h4180;
      else if (st) nxt = mpc;
      else if (er) nxt = ep;
      else if (ns == 2'd1) nxt = pd + 32'd4 + 32'(off * 4);
      else if (ns == 2'd2) nxt = (pd & 32'hF000_0000) + {4'd0, ix, 2'b00};
      else if (ns == 2'd3) nxt = rs;
      else nxt = mpc + 32'd4;
      @(posedge clk);
      mpc = nxt;
      mvalid = 1'b1;
      #1;
   endtask

   task automatic seq(input logic st);
      step(0, 0, st, 0, 0, 2'd0, 0, 0, 0, 0, 0);
   endtask

   task automatic jr(input logic [31:0] tgt);
      step(0, 0, 0, 0, 0, 2'd3, 1, mpc - 32'd4, 0, 0, tgt);
   endtask

   function automatic logic [31:0] legal_addr();
      return 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
   endfunction

   initial begin
      reset = 1; int_req = 0; stall = 0; eret_d = 0; epc = 0; npc_sel = 0;
      is_jump_d = 0; pc_d = 0; imm16_d = 0; index_d = 0; rs_val_d = 0;
      @(posedge clk); #1;
      step(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
      repeat (4) seq(0);
      seq(1); seq(1); seq(0);
      repeat (2) seq(0);
      step(0, 0, 0, 0, 0, 2'd1, 1, 32'h3020, 16'hFFFE, 0, 0);
      seq(0);
      jr(32'h3002);
      jr(32'h7000);
      jr(32'h6FFC);
      jr(32'h2FFC);
      jr(32'h3040);
      step(0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 2'd2, 1, 32'h0000_4184, 0, 26'h0000C10, 0);
      step(0, 0, 1, 1, 32'h3100, 2'd0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h3100, 2'd0, 0, 0, 0, 0, 0);
      seq(0);
      step(0, 1, 0, 1, 32'h3200, 2'd0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 1, 32'h3300, 2'd3, 1, 0, 0, 0, 32'h5000);
      for (int i = 0; i < 400; i++) begin
         int r;
         logic [31:0] ep, rs;
         r  = $urandom_range(0, 99);
         ep = ($urandom_range(0, 7) == 0) ? $urandom : legal_addr();
         rs = ($urandom_range(0, 7) == 0) ? $urandom : legal_addr();
         step(r < 2, r >= 2 && r < 5, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, ep,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), mpc - 32'd4,
              16'($signed(6'($urandom_range(0, 63)))), 26'($urandom), rs);
      end
      begin
         int budget;
         budget = 5;
         while (sb.size() > 0 && budget > 0) begin
            @(negedge clk); #1;
            budget--;
         end
         cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
